// File: rtl/fc_fm_sequencer_pkg.sv
// Shared types and default geometry for the FC feature-map read sequencer.
// The derived BEATS value is the number of buffer reads per neuron.
package fc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fc_state_t;

    localparam int DEF_FM_SIZE    = 384;
    localparam int DEF_CHUNK      = 8;
    localparam int DEF_NUM_NEURON = 10;
    localparam int DEF_BEATS      = DEF_FM_SIZE / DEF_CHUNK;

    function automatic int beats_of(input int fm_size, input int chunk);
        return fm_size / chunk;
    endfunction

endpackage

// File: rtl/fc_fm_sequencer_if.sv
// Buffer/MAC-facing signal bundle of the FC sequencer.
// FC_SEQ_PERF_EN adds the o_stall_cnt performance counter.
interface fc_fm_sequencer_if #(
    parameter int ADDR_W = 16
) ();

    logic              i_fc_start;
    logic              i_fc_clear;
    logic              i_fc_ready;
    logic [ADDR_W-1:0] o_fc_fm_addr;
    logic [ADDR_W-1:0] o_fc_wt_addr;
    logic              o_fc_data_valid;
    logic              o_fc_first;
    logic              o_fc_last;
    logic [7:0]        o_fc_neuron;
    logic              o_busy;
    logic              o_fc_done;
`ifdef FC_SEQ_PERF_EN
    logic [15:0]       o_stall_cnt;

    modport master (
        input  i_fc_start, i_fc_clear, i_fc_ready,
        output o_fc_fm_addr, o_fc_wt_addr,
        output o_fc_data_valid, o_fc_first, o_fc_last,
        output o_fc_neuron, o_busy, o_fc_done,
        output o_stall_cnt
    );

    modport slave (
        output i_fc_start, i_fc_clear, i_fc_ready,
        input  o_fc_fm_addr, o_fc_wt_addr,
        input  o_fc_data_valid, o_fc_first, o_fc_last,
        input  o_fc_neuron, o_busy, o_fc_done,
        input  o_stall_cnt
    );
`else
    modport master (
        input  i_fc_start, i_fc_clear, i_fc_ready,
        output o_fc_fm_addr, o_fc_wt_addr,
        output o_fc_data_valid, o_fc_first, o_fc_last,
        output o_fc_neuron, o_busy, o_fc_done
    );

    modport slave (
        output i_fc_start, i_fc_clear, i_fc_ready,
        input  o_fc_fm_addr, o_fc_wt_addr,
        input  o_fc_data_valid, o_fc_first, o_fc_last,
        input  o_fc_neuron, o_busy, o_fc_done
    );
`endif

endinterface

// File: rtl/fc_fm_sequencer_counter.sv
// Beat/neuron wrap counter with a running weight-word address.
// Clear has priority over the issue enable.
module fc_seq_counter #(
    parameter int BEATS      = 48,
    parameter int NUM_NEURON = 10,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] beat,
    output logic [7:0]        neuron,
    output logic [ADDR_W-1:0] wt_addr,
    output logic              beat_last,
    output logic              pass_last
);

    localparam logic [ADDR_W-1:0] BEAT_MAX = ADDR_W'(BEATS - 1);
    localparam logic [7:0]        NEUR_MAX = 8'(NUM_NEURON - 1);

    assign beat_last = (beat == BEAT_MAX);
    assign pass_last = beat_last && (neuron == NEUR_MAX);

    // wt_addr tracks neuron*BEATS+beat incrementally, no multiplier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat    <= '0;
            neuron  <= '0;
            wt_addr <= '0;
        end else if (clr) begin
            beat    <= '0;
            neuron  <= '0;
            wt_addr <= '0;
        end else if (en) begin
            wt_addr <= wt_addr + ADDR_W'(1);
            if (beat_last) begin
                beat   <= '0;
                neuron <= neuron + 8'd1;
            end else begin
                beat <= beat + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/fc_fm_sequencer.sv
// FC pass read sequencer: sweeps the pooled buffer once per neuron.
// Define FC_SEQ_PERF_EN to add the saturating o_stall_cnt counter.
module fc_fm_sequencer
    import fc_seq_pkg::*;
#(
    parameter int FM_SIZE    = DEF_FM_SIZE,
    parameter int CHUNK      = DEF_CHUNK,
    parameter int NUM_NEURON = DEF_NUM_NEURON,
    parameter int ADDR_W     = 16
) (
    input logic                clk,
    input logic                rst_n,
    fc_fm_sequencer_if.master  bus
);

    localparam int BEATS = beats_of(FM_SIZE, CHUNK);

    fc_state_t         state;
    logic              in_run;
    logic              issue;
    logic              cnt_clr;
    logic              beat_last;
    logic              pass_last;
    logic [ADDR_W-1:0] beat;
    logic [ADDR_W-1:0] wt_addr;
    logic [7:0]        neuron;

    logic              dv_q;
    logic              first_q;
    logic              last_q;
    logic [7:0]        neuron_q;
    logic              busy_q;
    logic              done_q;

    assign in_run  = (state == ST_RUN);
    assign issue   = in_run & bus.i_fc_ready & ~bus.i_fc_clear;
    assign cnt_clr = bus.i_fc_clear | ~in_run | (issue & pass_last);

    fc_seq_counter #(
        .BEATS      (BEATS),
        .NUM_NEURON (NUM_NEURON),
        .ADDR_W     (ADDR_W)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (cnt_clr),
        .en        (issue),
        .beat      (beat),
        .neuron    (neuron),
        .wt_addr   (wt_addr),
        .beat_last (beat_last),
        .pass_last (pass_last)
    );

    // Beat markers lag the issue by one cycle to line up with buffer data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            dv_q     <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            neuron_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.i_fc_clear) begin
            state    <= ST_IDLE;
            dv_q     <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            neuron_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            dv_q    <= issue;
            first_q <= issue & (beat == '0);
            last_q  <= issue & beat_last;
            done_q  <= 1'b0;
            if (issue) begin
                neuron_q <= neuron;
            end
            unique case (state)
                ST_IDLE: begin
                    if (bus.i_fc_start) begin
                        state  <= ST_RUN;
                        busy_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (issue && pass_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state  <= ST_DONE;
                    done_q <= 1'b1;
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_fc_fm_addr    = in_run ? ADDR_W'(beat * CHUNK) : '0;
    assign bus.o_fc_wt_addr    = in_run ? wt_addr : '0;
    assign bus.o_fc_data_valid = dv_q;
    assign bus.o_fc_first      = first_q;
    assign bus.o_fc_last       = last_q;
    assign bus.o_fc_neuron     = neuron_q;
    assign bus.o_busy          = busy_q;
    assign bus.o_fc_done       = done_q;

`ifdef FC_SEQ_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (bus.i_fc_clear) begin
            stall_q <= '0;
        end else if (state == ST_IDLE && bus.i_fc_start) begin
            stall_q <= '0;
        end else if (in_run && !bus.i_fc_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fc_fm_sequencer.sv
// Self-checking bench for fc_fm_sequencer: IDLE/clear vector table,
// then scoreboarded full passes with ready patterns, clear and reset.
module tb_fc_fm_sequencer;
    import fc_seq_pkg::*;

    localparam int BEATS = 48;
    localparam int NN    = 10;
    localparam int LIMIT = 3000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fc_fm_sequencer_if #(.ADDR_W(16)) bus ();

    fc_fm_sequencer #(
        .FM_SIZE    (384),
        .CHUNK      (8),
        .NUM_NEURON (10),
        .ADDR_W     (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic first;
        logic last;
        logic [7:0] neuron;
    } exp_t;

    typedef struct {
        logic st;
        logic cl;
        logic rd;
        logic busy;
        logic dv;
        logic [15:0] fm;
    } vec_t;

    exp_t sbq[$];
    vec_t vec[9];

    int checks = 0;
    int errors = 0;

    fc_state_t m_state = ST_IDLE;
    int m_beat   = 0;
    int m_neuron = 0;
    int m_stall  = 0;

    int n_beats, n_first, n_last, n_done;
    int cyc, done_cyc, last_dv_cyc;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_stats();
        n_beats     = 0;
        n_first     = 0;
        n_last      = 0;
        n_done      = 0;
        cyc         = -1;
        done_cyc    = -1;
        last_dv_cyc = -1;
    endtask

    // Drive one cycle, advance the reference model, check after the edge
    task automatic cycle(input logic st, input logic cl, input logic rd);
        exp_t e;
        bus.i_fc_start = st;
        bus.i_fc_clear = cl;
        bus.i_fc_ready = rd;
        if (m_state == ST_RUN) begin
            chk("fm_addr", 32'(bus.o_fc_fm_addr), m_beat * 8);
            chk("wt_addr", 32'(bus.o_fc_wt_addr),
                m_neuron * BEATS + m_beat);
        end else begin
            chk("fm_addr_idle", 32'(bus.o_fc_fm_addr), 0);
            chk("wt_addr_idle", 32'(bus.o_fc_wt_addr), 0);
        end
        if (cl) begin
            m_state  = ST_IDLE;
            m_beat   = 0;
            m_neuron = 0;
            m_stall  = 0;
        end else begin
            case (m_state)
                ST_IDLE: begin
                    if (st) begin
                        m_state = ST_RUN;
                        m_stall = 0;
                    end
                end
                ST_RUN: begin
                    if (rd) begin
                        e.first  = (m_beat == 0);
                        e.last   = (m_beat == BEATS - 1);
                        e.neuron = 8'(m_neuron);
                        sbq.push_back(e);
                        if (m_beat == BEATS - 1) begin
                            m_beat = 0;
                            if (m_neuron == NN - 1) begin
                                m_neuron = 0;
                                m_state  = ST_DRAIN;
                            end else begin
                                m_neuron++;
                            end
                        end else begin
                            m_beat++;
                        end
                    end else if (m_stall < 65535) begin
                        m_stall++;
                    end
                end
                ST_DRAIN: m_state = ST_DONE;
                default:  m_state = ST_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("busy", 32'(bus.o_busy), 32'(m_state != ST_IDLE));
        chk("done", 32'(bus.o_fc_done), 32'(m_state == ST_DONE));
        if (bus.o_fc_done) begin
            n_done++;
            done_cyc = cyc;
        end
        chk("data_valid", 32'(bus.o_fc_data_valid), 32'(sbq.size() != 0));
        if (bus.o_fc_data_valid && sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("first", 32'(bus.o_fc_first), 32'(e.first));
            chk("last", 32'(bus.o_fc_last), 32'(e.last));
            chk("neuron", 32'(bus.o_fc_neuron), 32'(e.neuron));
            n_beats++;
            if (bus.o_fc_first) n_first++;
            if (bus.o_fc_last) n_last++;
            last_dv_cyc = cyc;
        end
`ifdef FC_SEQ_PERF_EN
        chk("stall_cnt", 32'(bus.o_stall_cnt), m_stall);
`endif
    endtask

    task automatic run_until_idle(input bit toggle);
        int k;
        k = 0;
        while (m_state != ST_IDLE && k < LIMIT) begin
            cycle(1'b0, 1'b0, toggle ? (k % 2 == 0) : 1'b1);
            k++;
        end
        if (m_state != ST_IDLE) begin
            checks++;
            errors++;
            $display("FAIL timeout: pass did not end in %0d cycles", LIMIT);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_fm"}, 32'(bus.o_fc_fm_addr), 0);
        chk({tag, "_wt"}, 32'(bus.o_fc_wt_addr), 0);
        chk({tag, "_dv"}, 32'(bus.o_fc_data_valid), 0);
        chk({tag, "_first"}, 32'(bus.o_fc_first), 0);
        chk({tag, "_last"}, 32'(bus.o_fc_last), 0);
        chk({tag, "_neuron"}, 32'(bus.o_fc_neuron), 0);
        chk({tag, "_busy"}, 32'(bus.o_busy), 0);
        chk({tag, "_done"}, 32'(bus.o_fc_done), 0);
`ifdef FC_SEQ_PERF_EN
        chk({tag, "_stall"}, 32'(bus.o_stall_cnt), 0);
`endif
    endtask

    initial begin
        int k;
        bus.i_fc_start = 1'b0;
        bus.i_fc_clear = 1'b0;
        bus.i_fc_ready = 1'b0;

        vec[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vec[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        vec[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        vec[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
        vec[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
        vec[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'd8};
        vec[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd16};
        vec[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        vec[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};

        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            bus.i_fc_start = vec[i].st;
            bus.i_fc_clear = vec[i].cl;
            bus.i_fc_ready = vec[i].rd;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_busy", i), 32'(bus.o_busy),
                32'(vec[i].busy));
            chk($sformatf("vec%0d_dv", i), 32'(bus.o_fc_data_valid),
                32'(vec[i].dv));
            chk($sformatf("vec%0d_fm", i), 32'(bus.o_fc_fm_addr),
                32'(vec[i].fm));
        end

        // Full pass with ready held high
        clr_stats();
        cycle(1'b1, 1'b0, 1'b1);
        run_until_idle(1'b0);
        chk("full_beats", n_beats, 480);
        chk("full_first", n_first, NN);
        chk("full_last", n_last, NN);
        chk("full_done_cnt", n_done, 1);
        chk("full_last_dv_edge", last_dv_cyc, 480);
        chk("full_done_edge", done_cyc, 481);

        // Ready toggling 1,0 from the first RUN cycle
        clr_stats();
        cycle(1'b1, 1'b0, 1'b0);
        run_until_idle(1'b1);
        chk("tog_beats", n_beats, 480);
        chk("tog_done_cnt", n_done, 1);
`ifdef FC_SEQ_PERF_EN
        chk("tog_stall_final", 32'(bus.o_stall_cnt), 479);
`endif

        // Start pulse during RUN at beat 20 is ignored
        clr_stats();
        cycle(1'b1, 1'b0, 1'b1);
        k = 0;
        while (m_beat != 20 && k < LIMIT) begin
            cycle(1'b0, 1'b0, 1'b1);
            k++;
        end
        cycle(1'b1, 1'b0, 1'b1);
        run_until_idle(1'b0);
        chk("midstart_beats", n_beats, 480);
        chk("midstart_done_cnt", n_done, 1);

        // Clear at neuron 3 beat 5, then restart
        clr_stats();
        cycle(1'b1, 1'b0, 1'b1);
        k = 0;
        while (!(m_neuron == 3 && m_beat == 5) && k < LIMIT) begin
            cycle(1'b0, 1'b0, 1'b1);
            k++;
        end
        cycle(1'b0, 1'b1, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 1'b1);
        chk("clear_no_done", n_done, 0);
        clr_stats();
        cycle(1'b1, 1'b0, 1'b1);
        run_until_idle(1'b0);
        chk("restart_beats", n_beats, 480);
        chk("restart_done_cnt", n_done, 1);

        // Async reset while draining
        clr_stats();
        cycle(1'b1, 1'b0, 1'b1);
        k = 0;
        while (m_state != ST_DRAIN && k < LIMIT) begin
            cycle(1'b0, 1'b0, 1'b1);
            k++;
        end
        chk("drain_dv_before_rst", 32'(bus.o_fc_data_valid), 1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        m_state  = ST_IDLE;
        m_beat   = 0;
        m_neuron = 0;
        m_stall  = 0;
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr_stats();
        repeat (6) cycle(1'b0, 1'b0, 1'b0);
        chk("rst_no_done", n_done, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_fm_sequencer.md
# fc_fm_sequencer

Read-side controller for the pooled feature-map buffer that feeds the fully-connected layer. When the buffer raises its start pulse, this block runs the FC pass: for each output neuron it sweeps the buffer's 8-element read address across the whole feature map and emits the matching weight-word address. It also emits first/last/valid markers aligned to the buffer's read data. It sits between the pool-to-FC buffer (drives its `i_fc_fm_addr`) and the FC MAC array (which accepts beats via a ready signal).

## Interface
- `FM_SIZE`, 384: feature-map elements held in the buffer (8×6×8)
- `CHUNK`, 8: elements returned per buffer read
- `NUM_NEURON`, 10: FC output neurons per pass
- `ADDR_W`, 16: width of fm and weight address outputs
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `i_fc_start` in 1: one-cycle start pulse from the buffer
- `i_fc_clear` in 1: synchronous abort to IDLE
- `i_fc_ready` in 1: MAC accepts a beat this cycle
- `o_fc_fm_addr` out ADDR_W: element address to buffer, = beat×CHUNK
- `o_fc_wt_addr` out ADDR_W: weight word address, = neuron×BEATS + beat
- `o_fc_data_valid` out 1: buffer data on its output is a live beat
- `o_fc_first` out 1: beat 0 of a neuron, aligned with data_valid
- `o_fc_last` out 1: beat BEATS−1 of a neuron, aligned with data_valid
- `o_fc_neuron` out 8: neuron index, aligned with data_valid
- `o_busy` out 1: state ≠ IDLE
- `o_fc_done` out 1: one-cycle pass-complete pulse

## Operation
- BEATS = FM_SIZE/CHUNK (48). FM_SIZE must be a multiple of CHUNK; NUM_NEURON ≤ 256.
- States: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: counters at 0. `i_fc_start`=1 → RUN.
- RUN: an issue occurs when `i_fc_ready`=1. On an issue, beat increments. When beat = BEATS−1, beat wraps to 0 and neuron increments. An issue at beat BEATS−1 of neuron NUM_NEURON−1 → DRAIN.
- RUN with `i_fc_ready`=0: addresses hold. The buffer re-registers the same address, so its data stays stable.
- DRAIN: one cycle, lets the final data beat appear → DONE.
- DONE: `o_fc_done`=1 for one cycle → IDLE.
- `i_fc_start` while not IDLE: ignored.
- `i_fc_clear`: from any state → IDLE next edge, counters zeroed, data_valid dropped, no done pulse. Clear wins over a simultaneous start.
- Outside RUN, address outputs are 0.

## Timing
- Reset: all outputs 0, state IDLE.
- The buffer registers the address, so its data lags the address by 1 cycle. `o_fc_data_valid`, `o_fc_first`, `o_fc_last` and `o_fc_neuron` are therefore registered copies of the issue-cycle values, with 1-cycle latency.
- MAC must consume every beat flagged by `o_fc_data_valid`. Ready gates issue, not data.
- With ready held high, the start sampled at edge E0 gives:
  - first address 0 after E0;
  - 480 issues, the last after E479;
  - last data_valid after E480;
  - `o_fc_done` high for one cycle after E481.
- Reset asserted mid-pass: immediate return to reset values, pass lost.

## Configuration
- `FC_SEQ_PERF_EN` defined: adds output `o_stall_cnt` [15:0].
  - Counts RUN cycles with `i_fc_ready`=0, saturating at 0xFFFF.
  - Cleared on start acceptance, on clear and on reset.
  - Held after done.
- Undefined: port and counter absent; otherwise identical.

## Structure
- Shared package `fc_seq_pkg` holds:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - default FM_SIZE/CHUNK/NUM_NEURON constants;
  - the derived BEATS constant.
- One natural sub-module: `fc_seq_counter`, the beat/neuron wrap counter with issue enable and terminal flags. The FSM and alignment registers stay in the top.

## Test plan
- Full pass, ready=1, defaults:
  - exactly 480 data_valid beats;
  - fm_addr 0,8,…,376 repeated 10 times;
  - wt_addr 0…479;
  - 10 first and 10 last pulses;
  - done after E481.
- Ready toggling 1,0 each cycle:
  - addresses hold through every ready=0 cycle;
  - still 480 beats, neuron order unchanged;
  - with PERF_EN, `o_stall_cnt`=479 at done.
- Start pulse in mid-RUN at beat 20: ignored, no counter reset, single done pulse.
- Clear at neuron 3, beat 5: IDLE next edge, busy=0, no done; a later start restarts at addr 0, neuron 0.
- Clear and start in the same cycle from IDLE: stays IDLE.
- rst_n low during DRAIN: all outputs 0 asynchronously, no done after release.
